mux16x1_bus: RTL and testbench
==============================

Name: mux16x1_bus

Overview:
- 16-to-1 multiplexer over a WIDTH-bit data bus, with a registered output.
- A 4-bit select S picks one of sixteen independent inputs D0..D15; the chosen word appears on Y one clock later.
- Used as a generic datapath selector wherever a bus source must be chosen from up to 16 producers; the output is a flop stage that isolates downstream timing.

Parameters:
- WIDTH, 3, bit width of every data input and of Y (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock; sole clock domain
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- en  input  1  load enable; when high, the output register captures the selected input
- S  input  4  select index, 0..15, unsigned
- D0 .. D15  input  WIDTH each  data inputs; Dk is selected when S == k
- Y  output  WIDTH  registered selected data
- y_valid  output  1  high for the cycle(s) after a load; indicates Y holds a captured value

Behaviour:
- All state updates on the rising edge of clk only; no latches, no asynchronous paths.
- Reset (rst_n == 0 at a rising edge): Y <= 0 (all WIDTH bits), y_valid <= 0. Reset has priority over en.
- Normal load (rst_n == 1, en == 1): Y <= Dk where k = S; y_valid <= 1.
- Hold (rst_n == 1, en == 0): Y and y_valid keep their previous values.
- Latency: exactly 1 cycle from the S/D/en sample edge to Y. There is no combinational path from inputs to Y.
- All 16 select codes are valid. There is no out-of-range case, no default fill and no X propagation for a known S.
- A select of X/Z in simulation drives Y to X for that load. Synthesis must still treat S as a full 16-way decode with no priority encoding.
- S or Dk changing between edges has no effect; only values at the sampling edge matter.
- Reset deasserted mid-operation: the first edge with rst_n == 1 and en == 1 loads normally; there is no warm-up cycle.
- Back-to-back loads with changing S every cycle: Y tracks with a 1-cycle lag, with no bubbles.
- Y width exactly equals WIDTH; no zero-extension or truncation of inputs.

Decomposition:
- Shared package mux_bus_pkg:
  - localparam SEL_W = 4
  - localparam NUM_IN = 16
  - default DATA_W = 3
  - typedef sel_t (logic [SEL_W-1:0])
- One combinational sub-module, mux16x1_comb, parameterised on WIDTH. It takes S and D0..D15 and produces the unregistered selection with a case/array-index decode.
- The top level instantiates mux16x1_comb and adds the output register, the en gating and y_valid.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with D5 = 3'b101, S = 5, en = 1 -> Y == 3'b000 and y_valid == 0 during reset. On the first edge after release, Y == 3'b101.
- Full select sweep: set D0..D15 = 000, 001, 010, 011, 100, 101, 110, 111, 001, 010, 011, 100, 101, 110, 111, 000, en = 1, and step S = 0..15, one per cycle. Y must equal the same sequence one cycle later: S = 0 -> 000, S = 7 -> 111, S = 8 -> 001, S = 14 -> 111, S = 15 -> 000.
- Hold: load S = 4 (Y = 100), then drop en and change S to 9 and D4 to 3'b011 -> Y stays 3'b100 and y_valid stays 1 until en returns high.
- Input isolation: S = 10 with en = 1; toggle every Dk except D10 each cycle -> Y constant at the D10 value (011).
- Reset mid-stream: during the sweep, assert rst_n = 0 for 1 cycle at S = 6 -> Y == 000 and y_valid == 0 the next cycle. The next load at S = 7 gives 111.
- Width parameter: instantiate with WIDTH = 8, D3 = 8'hA5, D12 = 8'h3C. S = 3 -> 8'hA5 and S = 12 -> 8'h3C, each after 1 cycle.

Source files
------------

// File: rtl/mux16x1_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_bus_pkg
// Description : Shared constants and types for the 16-to-1 bus multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_bus_pkg;

    // Width of the select index
    localparam int SEL_W  = 4;

    // Number of selectable sources
    localparam int NUM_IN = 16;

    // Default data bus width
    localparam int DATA_W = 3;

    // Select index type
    typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_bus_pkg
`default_nettype wire

// File: rtl/mux16x1_comb.sv
`default_nettype none
// ============================================================================
// Module      : mux16x1_comb
// Description : Unregistered 16-way data selector. S is fully decoded as a
//               parallel case; no priority chain is implied.
// Revision    : 1.0 - initial release
// ============================================================================
module mux16x1_comb
    import mux_bus_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  sel_t             S,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic [WIDTH-1:0] D8,
    input  logic [WIDTH-1:0] D9,
    input  logic [WIDTH-1:0] D10,
    input  logic [WIDTH-1:0] D11,
    input  logic [WIDTH-1:0] D12,
    input  logic [WIDTH-1:0] D13,
    input  logic [WIDTH-1:0] D14,
    input  logic [WIDTH-1:0] D15,
    output logic [WIDTH-1:0] Y
);

    // Parallel decode of all sixteen codes; an unknown select yields X
    always_comb begin
        Y = '0;
        unique case (S)
            4'd0:    Y = D0;
            4'd1:    Y = D1;
            4'd2:    Y = D2;
            4'd3:    Y = D3;
            4'd4:    Y = D4;
            4'd5:    Y = D5;
            4'd6:    Y = D6;
            4'd7:    Y = D7;
            4'd8:    Y = D8;
            4'd9:    Y = D9;
            4'd10:   Y = D10;
            4'd11:   Y = D11;
            4'd12:   Y = D12;
            4'd13:   Y = D13;
            4'd14:   Y = D14;
            4'd15:   Y = D15;
            default: Y = 'x;
        endcase
    end

endmodule : mux16x1_comb
`default_nettype wire

// File: rtl/mux16x1_bus.sv
`default_nettype none
// ============================================================================
// Module      : mux16x1_bus
// Description : 16-to-1 WIDTH-bit bus multiplexer with a registered output,
//               load enable and a valid flag. One cycle from sample to Y.
// Revision    : 1.0 - initial release
// ============================================================================
module mux16x1_bus
    import mux_bus_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  sel_t             S,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic [WIDTH-1:0] D8,
    input  logic [WIDTH-1:0] D9,
    input  logic [WIDTH-1:0] D10,
    input  logic [WIDTH-1:0] D11,
    input  logic [WIDTH-1:0] D12,
    input  logic [WIDTH-1:0] D13,
    input  logic [WIDTH-1:0] D14,
    input  logic [WIDTH-1:0] D15,
    output logic [WIDTH-1:0] Y,
    output logic             y_valid
);

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    mux16x1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .S   (S),
        .D0  (D0),
        .D1  (D1),
        .D2  (D2),
        .D3  (D3),
        .D4  (D4),
        .D5  (D5),
        .D6  (D6),
        .D7  (D7),
        .D8  (D8),
        .D9  (D9),
        .D10 (D10),
        .D11 (D11),
        .D12 (D12),
        .D13 (D13),
        .D14 (D14),
        .D15 (D15),
        .Y   (w_sel)
    );

    // Output stage: reset wins over load, load captures the selection, else hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_y     <= w_sel;
            r_valid <= 1'b1;
        end
    end

    assign Y       = r_y;
    assign y_valid = r_valid;

endmodule : mux16x1_bus
`default_nettype wire

// File: tb/tb_mux16x1_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux16x1_bus
// Description : Self-checking bench for mux16x1_bus (WIDTH = 3 and WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux16x1_bus;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 3 instance signals
    logic       rst_n3;
    logic       en3;
    logic [3:0] s3;
    logic [2:0] d3 [16];
    logic [2:0] y3;
    logic       v3;

    // WIDTH = 8 instance signals
    logic       rst_n8;
    logic       en8;
    logic [3:0] s8;
    logic [7:0] d8 [16];
    logic [7:0] y8;
    logic       v8;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] y;
        logic       v;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] s;
        logic [2:0] exp_y;
        logic       exp_v;
        string      name;
    } vec_t;

    vec_t vt[$];

    mux16x1_bus #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .en(en3), .S(s3),
        .D0(d3[0]),   .D1(d3[1]),   .D2(d3[2]),   .D3(d3[3]),
        .D4(d3[4]),   .D5(d3[5]),   .D6(d3[6]),   .D7(d3[7]),
        .D8(d3[8]),   .D9(d3[9]),   .D10(d3[10]), .D11(d3[11]),
        .D12(d3[12]), .D13(d3[13]), .D14(d3[14]), .D15(d3[15]),
        .Y(y3), .y_valid(v3)
    );

    mux16x1_bus #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .en(en8), .S(s8),
        .D0(d8[0]),   .D1(d8[1]),   .D2(d8[2]),   .D3(d8[3]),
        .D4(d8[4]),   .D5(d8[5]),   .D6(d8[6]),   .D7(d8[7]),
        .D8(d8[8]),   .D9(d8[9]),   .D10(d8[10]), .D11(d8[11]),
        .D12(d8[12]), .D13(d8[13]), .D14(d8[14]), .D15(d8[15]),
        .Y(y8), .y_valid(v8)
    );

    // Pop the oldest expectation and compare it with the observed output
    task automatic check(input string nm, input logic [7:0] ay, input logic av);
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got y=%h v=%b", nm, ay, av);
        end else begin
            x = sb.pop_front();
            if (ay !== x.y || av !== x.v) begin
                bad++;
                $display("FAIL %s: got y=%h v=%b, expected y=%h v=%b",
                         nm, ay, av, x.y, x.v);
            end
        end
    endtask

    // Drive one cycle on the 3-bit instance and check one cycle later
    task automatic step3(input logic r, input logic e, input logic [3:0] s,
                         input logic [2:0] ey, input logic ev, input string nm);
        rst_n3 = r;
        en3    = e;
        s3     = s;
        sb.push_back('{y: {5'b0, ey}, v: ev});
        @(posedge clk);
        #1;
        check(nm, {5'b0, y3}, v3);
    endtask

    // Drive one cycle on the 8-bit instance and check one cycle later
    task automatic step8(input logic r, input logic e, input logic [3:0] s,
                         input logic [7:0] ey, input logic ev, input string nm);
        rst_n8 = r;
        en8    = e;
        s8     = s;
        sb.push_back('{y: ey, v: ev});
        @(posedge clk);
        #1;
        check(nm, y8, v8);
    endtask

    task automatic load_pattern3();
        logic [2:0] pat [16];
        pat = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111,
                3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
        for (int k = 0; k < 16; k++) d3[k] = pat[k];
    endtask

    task automatic add(input logic r, input logic e, input logic [3:0] s,
                       input logic [2:0] ey, input logic ev, input string nm);
        vec_t v;
        v.rst_n = r; v.en = e; v.s = s; v.exp_y = ey; v.exp_v = ev; v.name = nm;
        vt.push_back(v);
    endtask

    initial begin
        logic [2:0] sweep_exp [16];
        sweep_exp = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111,
                      3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};

        // Idle the 8-bit instance in reset while the 3-bit one is exercised
        rst_n8 = 1'b0; en8 = 1'b0; s8 = 4'd0;
        for (int k = 0; k < 16; k++) d8[k] = 8'(k * 8'h11);
        d8[3]  = 8'hA5;
        d8[12] = 8'h3C;

        rst_n3 = 1'b0; en3 = 1'b1; s3 = 4'd5;
        load_pattern3();

        // Vector table: reset, release, full sweep, mid-stream reset
        add(1'b0, 1'b1, 4'd5, 3'b000, 1'b0, "reset_c0");
        add(1'b0, 1'b1, 4'd5, 3'b000, 1'b0, "reset_c1");
        add(1'b1, 1'b1, 4'd5, 3'b101, 1'b1, "release_load");
        for (int k = 0; k < 16; k++)
            add(1'b1, 1'b1, 4'(k), sweep_exp[k], 1'b1, $sformatf("sweep_s%0d", k));
        add(1'b1, 1'b1, 4'd4, 3'b100, 1'b1, "midrst_s4");
        add(1'b1, 1'b1, 4'd5, 3'b101, 1'b1, "midrst_s5");
        add(1'b0, 1'b1, 4'd6, 3'b000, 1'b0, "midrst_s6_reset");
        add(1'b1, 1'b1, 4'd7, 3'b111, 1'b1, "midrst_s7_load");
        add(1'b1, 1'b1, 4'd4, 3'b100, 1'b1, "hold_preload");

        for (int i = 0; i < vt.size(); i++)
            step3(vt[i].rst_n, vt[i].en, vt[i].s, vt[i].exp_y, vt[i].exp_v, vt[i].name);

        // Hold: en low, S and D4 change, Y keeps 100
        d3[4] = 3'b011;
        for (int c = 0; c < 3; c++)
            step3(1'b1, 1'b0, 4'd9, 3'b100, 1'b1, $sformatf("hold_c%0d", c));
        step3(1'b1, 1'b1, 4'd9, 3'b010, 1'b1, "hold_release_s9");
        step3(1'b1, 1'b1, 4'd4, 3'b011, 1'b1, "hold_new_d4");
        load_pattern3();

        // Input isolation: every Dk except D10 toggles each cycle
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 16; k++)
                if (k != 10) d3[k] = ~d3[k];
            step3(1'b1, 1'b1, 4'd10, 3'b011, 1'b1, $sformatf("isolate_c%0d", c));
        end
        load_pattern3();

        // Reset must win even with en low
        step3(1'b1, 1'b1, 4'd7, 3'b111, 1'b1, "pre_rst_en0");
        step3(1'b0, 1'b0, 4'd7, 3'b000, 1'b0, "rst_en0");
        step3(1'b1, 1'b0, 4'd7, 3'b000, 1'b0, "idle_after_rst");
        step3(1'b1, 1'b1, 4'd14, 3'b111, 1'b1, "load_s14");

        // WIDTH = 8 instance
        step8(1'b0, 1'b1, 4'd3, 8'h00, 1'b0, "w8_reset");
        step8(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, "w8_s3");
        step8(1'b1, 1'b1, 4'd12, 8'h3C, 1'b1, "w8_s12");
        step8(1'b1, 1'b0, 4'd0, 8'h3C, 1'b1, "w8_hold");
        step8(1'b1, 1'b1, 4'd15, 8'hFF, 1'b1, "w8_s15");
        step8(1'b1, 1'b1, 4'd7, 8'h77, 1'b1, "w8_s7");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux16x1_bus
`default_nettype wire
